// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key codes are row*4+col; column drive and row sense are both active-low.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } scan_state_t;

    localparam int KEY_W = 5;

    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Lowest-index row reading low; only meaningful when at least one row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        if (!rows[2]) idx = 2'd2;
        if (!rows[1]) idx = 2'd1;
        if (!rows[0]) idx = 2'd0;
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column dwell counter: pulses tick on the last cycle of each dwell, then reloads.
// clear restarts the dwell whenever the driven column changes.
module keypad_tick_gen #(
    parameter int SCAN_DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synchronises rows, rotates the column drive, debounces one
// key at a time and emits a single keypad_pressed strobe per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       row_i,
    output logic [3:0]       col_o,
    output logic [KEY_W-1:0] key,
    output logic             keypad_pressed
);

    localparam logic [7:0] DS = 8'(DEBOUNCE_SCANS);

    logic [3:0]  row_meta;
    logic [3:0]  row_sync;
    scan_state_t state;
    logic [1:0]  col;
    logic [1:0]  row;
    logic [7:0]  cnt;
    logic [7:0]  rcnt;
    logic        tick;
    logic        any_low;
    logic        tracked_low;
    logic [1:0]  first_low;
    logic        col_advance;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_i;
            row_sync <= row_meta;
        end
    end

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk_i),
        .rst  (rst_i),
        .clear(col_advance),
        .tick (tick)
    );

    assign any_low     = ~&row_sync;
    assign first_low   = lowest_low(row_sync);
    assign tracked_low = ~row_sync[row];

    // The column only moves on a tick, so col_o never changes mid-dwell.
    always_comb begin
        col_advance = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN:     col_advance = !any_low;
                ST_DEBOUNCE: col_advance = !tracked_low;
                ST_HELD:     col_advance = !tracked_low && ((rcnt + 8'd1) == DS);
                default:     col_advance = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_SCAN;
            col            <= 2'd0;
            row            <= 2'd0;
            cnt            <= 8'd0;
            rcnt           <= 8'd0;
            key            <= '0;
            keypad_pressed <= 1'b0;
            col_o          <= 4'b1110;
        end else begin
            keypad_pressed <= 1'b0;
            if (col_advance) begin
                col   <= col + 2'd1;
                col_o <= col_drive(col + 2'd1);
            end
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (any_low) begin
                            row <= first_low;
                            // A single-sample debounce accepts on the capturing tick.
                            if (DS == 8'd1) begin
                                key            <= {1'b1, key_index(first_low, col)};
                                keypad_pressed <= 1'b1;
                                rcnt           <= 8'd0;
                                state          <= ST_HELD;
                            end else begin
                                cnt   <= 8'd1;
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (tracked_low) begin
                            if ((cnt + 8'd1) == DS) begin
                                key            <= {1'b1, key_index(row, col)};
                                keypad_pressed <= 1'b1;
                                cnt            <= 8'd0;
                                rcnt           <= 8'd0;
                                state          <= ST_HELD;
                            end else begin
                                cnt <= cnt + 8'd1;
                            end
                        end else begin
                            cnt   <= 8'd0;
                            state <= ST_SCAN;
                        end
                    end
                    ST_HELD: begin
                        if (!tracked_low) begin
                            if ((rcnt + 8'd1) == DS) begin
                                key[KEY_W-1] <= 1'b0;
                                rcnt         <= 8'd0;
                                state        <= ST_SCAN;
                            end else begin
                                rcnt <= rcnt + 8'd1;
                            end
                        end else begin
                            rcnt <= 8'd0;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4x4 membrane keypad, debounces one key at a time and produces the `key[4:0]` code and `keypad_pressed` strobe consumed by the game FSM and probed by the on-chip logic analyzer. It sits between the keypad pins and the `fsm` block, in the main game clock domain. Rows are synchronised, columns are driven one at a time, and each accepted press produces exactly one strobe.

## Interface

Parameters:
- `SCAN_DIV`, default 27000: cycles each column is driven per sample (1 ms at 27 MHz); legal range is ≥ 4.
- `DEBOUNCE_SCANS`, default 10: consecutive agreeing samples required to accept a press or a release; legal range is 1..255.

Ports:
- `clk_i`  in  1  game clock; the only clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `row_i`  in  4  keypad rows; active-low, pulled up externally, asynchronous to `clk_i`.
- `col_o`  out  4  column drive; active-low one-hot.
- `key`  out  5  `key[4]` = key held; `key[3:0]` = row*4+col of the accepted key.
- `keypad_pressed`  out  1  one-cycle strobe on acceptance of a new press.

## Operation

- Rows pass through a 2-flop synchroniser. "Sample" means the synchronised row value on a tick.
- A tick is issued when the dwell counter reaches `SCAN_DIV`-1. The counter then reloads to 0. The counter is also forced to 0 on every column change.
- State machine:
  - SCAN: drive column c, starting at c=0. On a tick with any row low, capture r = the lowest-index low row, load cnt=1 and go to DEBOUNCE, keeping column c. If no row is low, advance c to (c+1) mod 4 and stay in SCAN.
  - DEBOUNCE: on each tick, if row r is low, increment cnt. When cnt reaches `DEBOUNCE_SCANS`, set key={1,r,c}, pulse `keypad_pressed` and go to HELD. If row r is high on a tick, go to SCAN and advance c.
  - HELD: keep column c driven. On each tick, a high row r increments rcnt; a low row r clears rcnt. When rcnt reaches `DEBOUNCE_SCANS`, clear `key[4]` (`key[3:0]` keeps its last value) and go to SCAN, advancing c.
- With `DEBOUNCE_SCANS`=1, the press is accepted on the capturing tick itself: SCAN goes straight to HELD.
- Only one key is tracked at a time. Other keys pressed while in HELD are ignored. A second row going low on the same column is also ignored.
- Auto-repeat: none. Holding a key yields exactly one strobe.

## Timing

- Reset values: `col_o`=4'b1110, `key`=5'b0_0000, `keypad_pressed`=0, state=SCAN, c=0, all counters 0, synchroniser flops at 4'b1111.
- `col_o` changes on the cycle after a tick, never mid-dwell. Rows therefore settle for `SCAN_DIV`-1 cycles before being sampled.
- `keypad_pressed` and `key[4]` rise on the same edge, the one following the accepting tick.
- `keypad_pressed` is high for exactly one cycle.
- `key` is stable for the whole of HELD.
- Minimum press latency, from stable low at the pin with the column already driven: 2 sync cycles plus `DEBOUNCE_SCANS` ticks.
- Worst-case additional latency: 3 full column dwells while the scan reaches the pressed column.
- Release latency: `DEBOUNCE_SCANS` ticks after the row reads high, plus 1 cycle.
- Reset mid-operation, in any state: all outputs return to their reset values on the next edge, with no strobe. If a key is still held after reset, a fresh debounce runs and produces one new strobe.
- Bounce during DEBOUNCE restarts the scan with no strobe. Bounce during HELD only resets rcnt.

## Structure

- Package `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, HELD);
  - `KEY_W`=5;
  - a key-index function `{row,col}`→4 bits.
- Sub-module `keypad_tick_gen` holds the dwell counter with a synchronous clear input and a tick output.
- The synchroniser, the FSM, the column rotator and the output registers live in `keypad_scanner`.

## Test plan

All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_SCANS`=3.

- Reset: hold `rst_i` 3 cycles -> `col_o`=4'b1110, `key`=0, `keypad_pressed`=0; column rotates 1110→1101→1011→0111 every 4 cycles.
- Clean press: pull row 1 low while column 2 is driven -> one `keypad_pressed` pulse and `key`=5'b1_0110, at the third tick after capture; `col_o` stays 4'b1011 while held.
- Bounce: row 1 low for 1 tick, high, then low again -> no strobe during the bounce; after a stable press, exactly one strobe with `key`=5'b1_0110.
- Release: from HELD, rows all high -> `key`=5'b0_0110 after 3 ticks, no strobe, and scanning resumes at column 3.
- Two rows low (rows 0 and 3, column 1) -> `key`=5'b1_0001, one strobe only.
- Reset asserted mid-DEBOUNCE (cnt=2) -> no strobe; outputs at reset values next cycle; held key re-debounced, giving one strobe.
